// File: rtl/regfile_pkg.sv
// Shared parameters, requester indices and helpers for the register-bank write scheduler.
package regfile_pkg;

   localparam int unsigned N       = 8;
   localparam int unsigned NREG    = 4;
   localparam int unsigned AW      = $clog2(NREG);
   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_LD  = 1;

   // Arbiter memory: which requester won the most recent acceptance
   typedef enum logic {
      LAST_ALU = 1'b0,
      LAST_LD  = 1'b1
   } last_grant_e;

   // One-hot register select; addresses at or above NREG decode to all zeros
   function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
      logic [NREG-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         r[i] = (addr == AW'(i));
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Requester, write-path and hazard-query signals between the core and the scheduler.
interface regfile_write_scheduler_if;
   import regfile_pkg::*;

   logic            alu_valid;
   logic [AW-1:0]   alu_addr;
   logic [N-1:0]    alu_data;
   logic            alu_ready;

   logic            ld_valid;
   logic [AW-1:0]   ld_addr;
   logic [N-1:0]    ld_data;
   logic            ld_ready;

   logic [NREG-1:0] reg_load_en;
   logic [N-1:0]    reg_wdata;

   logic [AW-1:0]   rd_addr;
   logic            rd_hazard;

   // Core side: issues requests and hazard queries
   modport master (
      output alu_valid, alu_addr, alu_data,
      input  alu_ready,
      output ld_valid, ld_addr, ld_data,
      input  ld_ready,
      input  reg_load_en, reg_wdata,
      output rd_addr,
      input  rd_hazard
   );

   // Scheduler side
   modport slave (
      input  alu_valid, alu_addr, alu_data,
      output alu_ready,
      input  ld_valid, ld_addr, ld_data,
      output ld_ready,
      output reg_load_en, reg_wdata,
      input  rd_addr,
      output rd_hazard
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; owns the last-grant flop.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   last_grant_e last_q;
   last_grant_e last_d;

   // Last-grant register; reset favours the ALU on first contention
   always_ff @(posedge clk) begin
      if (Reset) begin
         last_q <= LAST_LD;
      end else begin
         last_q <= last_d;
      end
   end

   // Grant selection and last-grant update
   always_comb begin
      gnt    = '0;
      last_d = last_q;
      if (!Reset) begin
         unique case (req)
            2'b01:   gnt[1'(REQ_ALU)] = 1'b1;
            2'b10:   gnt[1'(REQ_LD)]  = 1'b1;
            2'b11: begin
               if (last_q == LAST_LD) gnt[1'(REQ_ALU)] = 1'b1;
               else                   gnt[1'(REQ_LD)]  = 1'b1;
            end
            default: gnt = '0;
         endcase
      end
      if (advance && (gnt != 2'b00)) begin
         last_d = gnt[1'(REQ_LD)] ? LAST_LD : LAST_ALU;
      end
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-bank write path.
module regfile_write_scheduler
   import regfile_pkg::*;
(
   input  logic                       clk,
   input  logic                       Reset,
   regfile_write_scheduler_if.slave   bus
);

   logic [1:0]      req;
   logic [1:0]      gnt;
   logic            accept;
   logic [NREG-1:0] load_en_q;
   logic [NREG-1:0] load_en_d;
   logic [N-1:0]    wdata_q;
   logic [N-1:0]    wdata_d;

   // Request vector in arbiter index order
   always_comb begin
      req                = '0;
      req[1'(REQ_ALU)]   = bus.alu_valid;
      req[1'(REQ_LD)]    = bus.ld_valid;
   end

   assign accept = |gnt;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .Reset   (Reset),
      .req     (req),
      .advance (accept),
      .gnt     (gnt)
   );

   assign bus.alu_ready = gnt[1'(REQ_ALU)];
   assign bus.ld_ready  = gnt[1'(REQ_LD)];

   // Next write stage: decode the winner, otherwise idle with data held
   always_comb begin
      load_en_d = '0;
      wdata_d   = wdata_q;
      if (gnt[1'(REQ_ALU)]) begin
         load_en_d = onehot_dec(bus.alu_addr);
         wdata_d   = bus.alu_data;
      end else if (gnt[1'(REQ_LD)]) begin
         load_en_d = onehot_dec(bus.ld_addr);
         wdata_d   = bus.ld_data;
      end
   end

   // Write-stage registers; reset discards any uncaptured write
   always_ff @(posedge clk) begin
      if (Reset) begin
         load_en_q <= '0;
         wdata_q   <= '0;
      end else begin
         load_en_q <= load_en_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.reg_load_en = load_en_q;
   assign bus.reg_wdata   = wdata_q;
   assign bus.rd_hazard   = (|load_en_q) && load_en_q[bus.rd_addr];

endmodule
